// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO (clk_tx domain): RAM write port, binary write
// pointer, published pointer and tx-view level/flags. Optional macro: FIFO_WR_OVF_CHK_EN.
module async_fifo_wr_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_tx,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH:0]   af_thresh,
   input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
   output logic                  wr_ready,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH:0]   wr_ptr_pub
`ifdef FIFO_WR_OVF_CHK_EN
   ,
   input  logic                  ovf_clr,
   output logic                  ovf_err
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH:0]   wr_ptr_q,     wr_ptr_d;
   logic [ADDR_WIDTH:0]   wr_ptr_pub_q, wr_ptr_pub_d;
   logic                  mem_we_q,     mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_waddr_q,  mem_waddr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
   logic [ADDR_WIDTH:0]   level_s;
   logic                  full_s;
   logic                  accept_s;

   // Level and flags from registered pointer and the (stale, hence pessimistic) read pointer.
   always_comb begin
      level_s     = wr_ptr_q - rd_ptr_sync;
      full_s      = (level_s >= DEPTH_C);
      almost_full = 1'b0;
      if (af_thresh > DEPTH_C) begin
         almost_full = full_s;
      end else begin
         almost_full = (level_s >= af_thresh);
      end
      accept_s = wr_en & ~full_s & ~rst;
   end

   assign wr_level = level_s;
   assign full     = full_s;
   assign wr_ready = accept_s;

   // Next-state for pointer, RAM write port and published pointer.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      mem_we_d     = 1'b0;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      wr_ptr_pub_d = wr_ptr_q;
      if (accept_s) begin
         wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
         mem_we_d    = 1'b1;
         mem_waddr_d = wr_ptr_q[ADDR_WIDTH-1:0];
         mem_wdata_d = wr_data;
      end else begin
         mem_we_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_tx or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= {(ADDR_WIDTH+1){1'b0}};
         wr_ptr_pub_q <= {(ADDR_WIDTH+1){1'b0}};
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         wr_ptr_pub_q <= wr_ptr_pub_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign wr_ptr_pub = wr_ptr_pub_q;

`ifdef FIFO_WR_OVF_CHK_EN
   logic ovf_err_q, ovf_err_d;

   // Sticky overflow: a dropped write sets it, and setting beats clearing.
   always_comb begin
      ovf_err_d = ovf_err_q;
      if (wr_en & full_s) begin
         ovf_err_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_err_d = 1'b0;
      end else begin
         ovf_err_d = ovf_err_q;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk_tx or posedge rst) begin
      if (rst) begin
         ovf_err_q <= 1'b0;
      end else begin
         ovf_err_q <= ovf_err_d;
      end
   end

   assign ovf_err = ovf_err_q;
`else
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed self-checking bench for async_fifo_wr_ctrl (ADDR_WIDTH=4, DEPTH=16).
module tb_async_fifo_wr_ctrl;

   logic       clk_tx = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [4:0] af_thresh;
   logic [4:0] rd_ptr_sync;
   logic       wr_ready, full, almost_full, mem_we;
   logic [4:0] wr_level, wr_ptr_pub;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata;
`ifdef FIFO_WR_OVF_CHK_EN
   logic       ovf_clr;
   logic       ovf_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_tx = ~clk_tx;

   async_fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk_tx      (clk_tx),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .af_thresh   (af_thresh),
      .rd_ptr_sync (rd_ptr_sync),
      .wr_ready    (wr_ready),
      .full        (full),
      .almost_full (almost_full),
      .wr_level    (wr_level),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata),
      .wr_ptr_pub  (wr_ptr_pub)
`ifdef FIFO_WR_OVF_CHK_EN
      ,
      .ovf_clr     (ovf_clr),
      .ovf_err     (ovf_err)
`endif
   );

   task automatic tick();
      @(posedge clk_tx);
      #1;
   endtask

   task automatic do_reset();
      wr_en = 1'b0;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; af_thresh = 5'd4; rd_ptr_sync = 5'd0;
`ifdef FIFO_WR_OVF_CHK_EN
      ovf_clr = 1'b0;
`endif
      #3;
      checks++; if (wr_level !== 5'd0) begin failures++; $display("FAIL rst_level got %0d exp 0", wr_level); end
      checks++; if (full !== 1'b0 || almost_full !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL rst_flags got %b%b%b exp 000", full, almost_full, wr_ready); end
      tick();
      rst = 1'b0;
      // five writes, then reset in the middle of a sixth
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
         tick();
      end
      checks++; if (wr_level !== 5'd5) begin failures++; $display("FAIL pre_rst_level got %0d exp 5", wr_level); end
      rst = 1'b1;
      #1;
      checks++; if (wr_level !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL midrst_flags level=%0d f=%b af=%b rdy=%b exp 0", wr_level, full, almost_full, wr_ready); end
      checks++; if (mem_we !== 1'b0 || mem_waddr !== 4'd0 || mem_wdata !== 8'd0 || wr_ptr_pub !== 5'd0) begin failures++; $display("FAIL midrst_mem we=%b a=%0d d=%0h pub=%0d exp 0", mem_we, mem_waddr, mem_wdata, wr_ptr_pub); end
      tick();
      rst = 1'b0; wr_en = 1'b0;
      tick();
      checks++; if (wr_level !== 5'd0 || full !== 1'b0) begin failures++; $display("FAIL post_rst level=%0d full=%b exp 0/0", wr_level, full); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      rd_ptr_sync = 5'd0; af_thresh = 5'd4;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
         #1;
         checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got %b exp 1", i, wr_ready); end
         tick();
         checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'(i) || mem_wdata !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL fill_mem[%0d] we=%b a=%0d d=%0h exp 1/%0d/%0h", i, mem_we, mem_waddr, mem_wdata, i, 8'hA0 + 8'(i)); end
      end
      // wr_en still high: this is the 17th attempt
      checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || wr_level !== 5'd16) begin failures++; $display("FAIL full_set f=%b rdy=%b lvl=%0d exp 1/0/16", full, wr_ready, wr_level); end
      checks++; if (wr_ptr_pub !== 5'd15) begin failures++; $display("FAIL pub_lag got %0d exp 15", wr_ptr_pub); end
      tick();
      checks++; if (mem_we !== 1'b0 || mem_waddr !== 4'd15 || wr_level !== 5'd16) begin failures++; $display("FAIL drop we=%b a=%0d lvl=%0d exp 0/15/16", mem_we, mem_waddr, wr_level); end
      checks++; if (wr_ptr_pub !== 5'd16) begin failures++; $display("FAIL pub_16 got %0d exp 16", wr_ptr_pub); end
`ifdef FIFO_WR_OVF_CHK_EN
      checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", ovf_err); end
`endif
      wr_en = 1'b0; af_thresh = 5'd17;
      #1;
      checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL af_track_full got %b exp 1", almost_full); end
      tick();
      checks++; if (wr_ptr_pub !== 5'd16 || wr_level !== 5'd16) begin failures++; $display("FAIL ptr_hold pub=%0d lvl=%0d exp 16/16", wr_ptr_pub, wr_level); end
`ifdef FIFO_WR_OVF_CHK_EN
      checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
      wr_en = 1'b1; ovf_clr = 1'b1;
      tick();
      checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set_prio got %b exp 1", ovf_err); end
      wr_en = 1'b0;
      tick();
      checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clr got %b exp 0", ovf_err); end
      ovf_clr = 1'b0;
`endif
   endtask

   task automatic test_almost_full();
      do_reset();
      af_thresh = 5'd12; rd_ptr_sync = 5'd0;
      for (int i = 0; i < 11; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      #1;
      checks++; if (almost_full !== 1'b0 || wr_level !== 5'd11) begin failures++; $display("FAIL af_11 af=%b lvl=%0d exp 0/11", almost_full, wr_level); end
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      #1;
      checks++; if (almost_full !== 1'b1 || wr_level !== 5'd12) begin failures++; $display("FAIL af_12 af=%b lvl=%0d exp 1/12", almost_full, wr_level); end
      rd_ptr_sync = 5'd1;
      #1;
      checks++; if (almost_full !== 1'b0 || wr_level !== 5'd11) begin failures++; $display("FAIL af_rd af=%b lvl=%0d exp 0/11", almost_full, wr_level); end
   endtask

   task automatic test_wrap_and_simul();
      do_reset();
      af_thresh = 5'd16;
      // advance both pointers to 30 while keeping the FIFO near empty
      for (int i = 0; i < 30; i++) begin
         rd_ptr_sync = 5'(i); wr_en = 1'b1;
         tick();
      end
      rd_ptr_sync = 5'd30;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
         tick();
         checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'((30 + i) % 16)) begin failures++; $display("FAIL wrap_addr[%0d] we=%b a=%0d exp 1/%0d", i, mem_we, mem_waddr, (30 + i) % 16); end
      end
      wr_en = 1'b0;
      #1;
      checks++; if (wr_level !== 5'd4 || full !== 1'b0) begin failures++; $display("FAIL wrap_level lvl=%0d f=%b exp 4/0", wr_level, full); end
      tick();
      checks++; if (wr_ptr_pub !== 5'd2) begin failures++; $display("FAIL wrap_pub got %0d exp 2", wr_ptr_pub); end
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         tick();
      end
      wr_en = 1'b0;
      #1;
      checks++; if (wr_level !== 5'd8) begin failures++; $display("FAIL simul_pre got %0d exp 8", wr_level); end
      wr_en = 1'b1; rd_ptr_sync = 5'd31;
      #1;
      checks++; if (wr_ready !== 1'b1 || wr_level !== 5'd7) begin failures++; $display("FAIL simul_mid rdy=%b lvl=%0d exp 1/7", wr_ready, wr_level); end
      tick();
      wr_en = 1'b0;
      #1;
      checks++; if (wr_level !== 5'd8 || full !== 1'b0) begin failures++; $display("FAIL simul_net lvl=%0d f=%b exp 8/0", wr_level, full); end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_almost_full();
      test_wrap_and_simul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
